// File: rtl/fetch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_flush_ctrl
// Purpose  : Fetch-side control for a short in-order pipeline. Owns the fetch
//            PC, issues instruction-memory requests, parks a returned word
//            while the pipeline is stalled, produces the one-cycle advance
//            strobe, and squashes younger slots on a flush code from the
//            branch unit.
// Ports    : clock, reset           - clock (rising edge) / async active-high reset
//            stall                  - downstream hazard hold
//            resultpc               - next fetch PC chosen by the branch unit
//            flash                  - flush code (00 none, 01 one slot, 10 two, 11 illegal)
//            imem_req/imem_addr     - memory request and address (== pc)
//            imem_rdata/imem_ready  - returned word and completion
//            pc, inst               - current fetch PC and IF-slot instruction
//            enable                 - pipeline-advance strobe
//            valid_if/id/ex         - slot-valid bits
//            flush_count            - saturating count of flushing advances
//            flash_err              - sticky illegal-flush-code flag
// Revision : 1.0 - initial release
// ============================================================================
module fetch_flush_ctrl #(
    parameter int                PC_W     = 12,
    parameter int                INST_W   = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [PC_W-1:0]   resultpc,
    input  logic [1:0]        flash,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic              enable,
    output logic              valid_if,
    output logic              valid_id,
    output logic              valid_ex,
    output logic [15:0]       flush_count,
    output logic              flash_err
);

    localparam logic [1:0]  c_ST_BOOT  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH = 2'd1;
    localparam logic [1:0]  c_ST_HOLD  = 2'd2;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] r_hold;
    logic              r_valid_if;
    logic              r_valid_id;
    logic              r_valid_ex;
    logic [15:0]       r_flush_count;
    logic              r_flash_err;

    logic              w_req;
    logic              w_advance;
    logic              w_capture;
    logic [INST_W-1:0] w_word;
    logic              w_squash_if;
    logic              w_squash_id;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        w_word      = imem_rdata;
        case (r_state)
            c_ST_BOOT: begin
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                // Request stays up with a stable address until ready; stall
                // only matters once the word has actually arrived.
                w_req = 1'b1;
                if (imem_ready) begin
                    if (stall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            c_ST_HOLD: begin
                // Word already parked; no re-fetch while waiting for the stall.
                w_word = r_hold;
                if (!stall) begin
                    w_advance   = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_ST_BOOT;
            end
        endcase
    end

    // Any nonzero code kills the IF slot; bit 1 (codes 10 and 11) also kills ID.
    assign w_squash_if = |flash;
    assign w_squash_id = flash[1];

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inst        <= NOP_INST;
            r_hold        <= NOP_INST;
            r_valid_if    <= 1'b0;
            r_valid_id    <= 1'b0;
            r_valid_ex    <= 1'b0;
            r_flush_count <= 16'd0;
            r_flash_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold <= imem_rdata;
            end
            if (w_advance) begin
                r_pc       <= resultpc;
                r_valid_ex <= r_valid_id;
                r_valid_id <= w_squash_id ? 1'b0 : r_valid_if;
                r_valid_if <= ~w_squash_if;
                r_inst     <= w_squash_if ? NOP_INST : w_word;
                if (w_squash_if && (r_flush_count != c_CNT_MAX)) begin
                    r_flush_count <= r_flush_count + 16'd1;
                end
                if (flash == 2'b11) begin
                    r_flash_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign enable      = w_advance;
    assign valid_if    = r_valid_if;
    assign valid_id    = r_valid_id;
    assign valid_ex    = r_valid_ex;
    assign flush_count = r_flush_count;
    assign flash_err   = r_flash_err;

endmodule
`default_nettype wire

// File: doc/fetch_flush_ctrl.md
Name: fetch_flush_ctrl

Overview:
- Fetch-side partner of the branch/prediction unit. Owns the fetch PC register and drives the instruction-memory request handshake.
- Feeds the fetched word and PC to the branch unit and decoder, and generates the pipeline advance strobe (`enable`).
- Consumes the branch unit's next-PC (`resultpc`) and flush code (`flash`), squashing 1 or 2 younger pipeline slots into NOP bubbles.

Parameters:
- PC_W, 12, fetch PC / memory address width
- INST_W, 16, instruction width
- RESET_PC, 0, PC value after reset
- NOP_INST, 16'h0000, word presented for squashed or invalid slots

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hazard hold from downstream; no advance while high
- resultpc  in  PC_W  next fetch PC from branch unit (sequential or redirected)
- flash  in  2  flush code: 00 none, 01 squash 1 slot, 10 squash 2 slots, 11 illegal
- imem_req  out  1  instruction-memory request
- imem_addr  out  PC_W  request address, equal to pc
- imem_rdata  in  INST_W  returned instruction, valid when imem_ready=1
- imem_ready  in  1  completes the request this cycle
- pc  out  PC_W  current fetch PC, to branch unit
- inst  out  INST_W  IF-slot instruction (NOP_INST when valid_if=0)
- enable  out  1  one-cycle pipeline-advance strobe
- valid_if, valid_id, valid_ex  out  1 each  slot-valid bits
- flush_count  out  16  number of advances with nonzero flash, saturating at 16'hFFFF
- flash_err  out  1  sticky; set when flash=11 is seen on an advance

Behaviour:
- Reset (async) values:
  - state=BOOT, pc=RESET_PC, inst register=NOP_INST
  - all valid bits 0, imem_req=0, enable=0
  - flush_count=0, flash_err=0, hold buffer=NOP_INST
- FSM states BOOT, FETCH, HOLD:
  - BOOT: imem_req=0, enable=0. Next state is FETCH unconditionally, one cycle after reset release.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready & !stall: advance this cycle, with enable=1 combinationally. Stay in FETCH.
    - imem_ready & stall: capture imem_rdata into the hold buffer and go to HOLD. enable=0, pc unchanged.
    - !imem_ready: stay in FETCH. req and addr stay stable. enable=0. stall has no effect.
  - HOLD: imem_req=0. When stall=0, advance using the hold buffer as the fetched word (enable=1) and go to FETCH.
- Advance effects, all registered on the advance edge:
  - pc <= resultpc
  - inst register <= fetched word
  - valid_ex <= valid_id, valid_id <= valid_if, valid_if <= 1
  - then the flash squash rules are applied
- Flash squash rules (flash is sampled only on advance cycles and ignored otherwise):
  - 01: valid_if <= 0 and inst register <= NOP_INST. The word just fetched is discarded.
  - 10: squash as 01, and also valid_id <= 0.
  - 11: treated as 10; flash_err <= 1.
  - Any nonzero code: flush_count increments unless it is already 16'hFFFF.
- Redirect: the branch unit computes resultpc for both the sequential and the branch cases. This block never adds +1 itself. Address arithmetic wraps modulo 2^PC_W, so pc=0xFFF with resultpc=0x000 is legal.
- Zero-wait memory: imem_ready may be high in the same cycle req rises. Sustained throughput is one advance per cycle.
- enable is never high in BOOT, or in any cycle without a completed fetch or a held word.
- stall rising during HOLD: remain in HOLD with no re-fetch; the hold buffer is retained.
- Reset asserted mid-request: imem_req drops asynchronously. The memory must tolerate an abandoned request.

Test Plan:
- Reset then release; imem_ready tied 1; resultpc=pc+1 → BOOT 1 cycle, then imem_addr 0,1,2,3 on consecutive cycles. enable=1 each cycle. valid_if,id,ex become 1 after 1, 2, 3 advances.
- imem_ready low for 3 cycles at pc=5 → imem_req held 1 with addr 5 throughout. enable=0 for 3 cycles. Advance on the 4th cycle, then inst=fetched word.
- At pc=7 with ready=1, raise stall for 4 cycles, rdata=16'hA5A5 → HOLD entered, imem_req=0 during stall. When stall drops: enable=1, inst=16'hA5A5, and the next request is issued at resultpc.
- Steady stream, then flash=01 with resultpc=0x040 on one advance → next inst=NOP_INST, valid_if=0, next addr=0x040, flush_count=1.
- flash=10 on an advance → valid_if=0 and valid_id=0 on the next cycle, valid_ex=previous valid_id, flush_count increments. Then flash=11 → same squash, flash_err=1 and it stays 1.
- Reset asserted while in FETCH waiting for ready → imem_req=0 and pc=RESET_PC before the next clock edge. All valid bits 0; flush_count=0.
